// File: rtl/lidar_packet_tx.sv
// lidar_packet_tx: assembles a LiDAR scan packet (header, CT, LSN, encoded
// angles, XOR checksum, samples) and streams it one byte at a time over a
// valid/ready byte interface to a UART transmitter.
// Optional build macro: LIDAR_TX_CORRUPT_EN adds corrupt_in, which flips
// checksum bit 0 of the packet it was sampled with.
module lidar_packet_tx #(
    parameter int MAX_SAMPLES = 40
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic [7:0]  ct_in,
    input  logic [7:0]  lsn_in,
    input  logic [14:0] fsa_in,
    input  logic [14:0] lsa_in,
    input  logic [15:0] sample_in,
    input  logic        sample_valid_in,
    output logic        sample_ready_out,
    output logic [7:0]  tx_data_out,
    output logic        tx_valid_out,
    input  logic        tx_ready_in,
    output logic        busy_out,
    output logic        done_out,
`ifdef LIDAR_TX_CORRUPT_EN
    input  logic        corrupt_in,
`endif
    output logic        error_out
);

    localparam int IDX_W = $clog2(MAX_SAMPLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND_HDR,
        ST_SEND_SAMPLES,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [7:0]        ct_reg;
    logic [7:0]        lsn_reg;
    logic [15:0]       fsa_e_reg;
    logic [15:0]       lsa_e_reg;
    logic [15:0]       cs_reg;
    logic [IDX_W-1:0]  load_idx_reg;
    logic [IDX_W-1:0]  rd_idx_reg, rd_idx_next;
    logic [IDX_W-1:0]  rd_addr;
    logic [3:0]        hdr_cnt_reg;
    logic              hi_reg;
    logic [15:0]       rd_data_reg;
    logic              error_reg;
    logic              corrupt_reg;
    logic [15:0]       cs_out;

    logic [15:0]       buffer [MAX_SAMPLES];

    logic              lsn_bad;
    logic              start_ok;
    logic              sample_fire;
    logic              tx_fire;
    logic              last_load;
    logic              last_hdr;
    logic              last_sample;

    assign lsn_bad     = (lsn_in == 8'd0) || (lsn_in > 8'(MAX_SAMPLES));
    assign start_ok    = start_in && !lsn_bad;
    assign sample_fire = (state_reg == ST_LOAD) && sample_valid_in;
    assign tx_fire     = tx_valid_out && tx_ready_in;
    assign last_load   = sample_fire && ((8'(load_idx_reg) + 8'd1) == lsn_reg);
    assign last_hdr    = tx_fire && (hdr_cnt_reg == 4'd9);
    assign last_sample = tx_fire && hi_reg && ((8'(rd_idx_reg) + 8'd1) == lsn_reg);

`ifdef LIDAR_TX_CORRUPT_EN
    assign cs_out = cs_reg ^ {15'd0, corrupt_reg};
`else
    assign cs_out = cs_reg;
`endif

    // Sample read pointer advances as the high byte leaves so the next word is
    // already in rd_data_reg when its low byte is needed (no bubbles).
    always_comb begin
        rd_idx_next = rd_idx_reg;
        if (state_reg == ST_IDLE) begin
            rd_idx_next = '0;
        end else if ((state_reg == ST_SEND_SAMPLES) && tx_fire && hi_reg) begin
            rd_idx_next = rd_idx_reg + 1'b1;
        end
        rd_addr = (32'(rd_idx_next) < MAX_SAMPLES) ? rd_idx_next : '0;
    end

    // Next-state and output decode.
    always_comb begin
        state_next       = state_reg;
        sample_ready_out = 1'b0;
        tx_valid_out     = 1'b0;
        tx_data_out      = 8'h00;
        busy_out         = (state_reg != ST_IDLE);
        done_out         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_ok) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                sample_ready_out = 1'b1;
                if (last_load) state_next = ST_SEND_HDR;
            end
            ST_SEND_HDR: begin
                tx_valid_out = 1'b1;
                case (hdr_cnt_reg)
                    4'd0:    tx_data_out = 8'hAA;
                    4'd1:    tx_data_out = 8'h55;
                    4'd2:    tx_data_out = ct_reg;
                    4'd3:    tx_data_out = lsn_reg;
                    4'd4:    tx_data_out = fsa_e_reg[7:0];
                    4'd5:    tx_data_out = fsa_e_reg[15:8];
                    4'd6:    tx_data_out = lsa_e_reg[7:0];
                    4'd7:    tx_data_out = lsa_e_reg[15:8];
                    4'd8:    tx_data_out = cs_out[7:0];
                    4'd9:    tx_data_out = cs_out[15:8];
                    default: tx_data_out = 8'h00;
                endcase
                if (last_hdr) state_next = ST_SEND_SAMPLES;
            end
            ST_SEND_SAMPLES: begin
                tx_valid_out = 1'b1;
                tx_data_out  = hi_reg ? rd_data_reg[15:8] : rd_data_reg[7:0];
                if (last_sample) state_next = ST_DONE;
            end
            ST_DONE: begin
                done_out   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign error_out = error_reg;

    // State, descriptor capture, checksum accumulation and byte counters.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_reg    <= ST_IDLE;
            ct_reg       <= '0;
            lsn_reg      <= '0;
            fsa_e_reg    <= '0;
            lsa_e_reg    <= '0;
            cs_reg       <= '0;
            load_idx_reg <= '0;
            rd_idx_reg   <= '0;
            hdr_cnt_reg  <= '0;
            hi_reg       <= 1'b0;
            error_reg    <= 1'b0;
            corrupt_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rd_idx_reg <= rd_idx_next;
            error_reg  <= (state_reg == ST_IDLE) && start_in && lsn_bad;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        ct_reg       <= ct_in;
                        lsn_reg      <= lsn_in;
                        fsa_e_reg    <= {fsa_in, 1'b1};
                        lsa_e_reg    <= {lsa_in, 1'b1};
                        cs_reg       <= 16'h55AA ^ {lsn_in, ct_in}
                                        ^ {fsa_in, 1'b1} ^ {lsa_in, 1'b1};
                        load_idx_reg <= '0;
                        hdr_cnt_reg  <= '0;
                        hi_reg       <= 1'b0;
`ifdef LIDAR_TX_CORRUPT_EN
                        corrupt_reg  <= corrupt_in;
`else
                        corrupt_reg  <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (sample_fire) begin
                        cs_reg       <= cs_reg ^ sample_in;
                        load_idx_reg <= load_idx_reg + 1'b1;
                    end
                end
                ST_SEND_HDR: begin
                    if (tx_fire) hdr_cnt_reg <= hdr_cnt_reg + 4'd1;
                end
                ST_SEND_SAMPLES: begin
                    if (tx_fire) hi_reg <= ~hi_reg;
                end
                default: ;
            endcase
        end
    end

    // Sample buffer: one write port (LOAD), one registered read port.
    always_ff @(posedge clk_in) begin
        if (sample_fire) buffer[load_idx_reg] <= sample_in;
        rd_data_reg <= buffer[rd_addr];
    end

endmodule

// File: tb/tb_lidar_packet_tx.sv
// tb_lidar_packet_tx: directed and randomized packets checked against a
// byte-list reference model of the packet format.
module tb_lidar_packet_tx;

    localparam int MAX = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ct = '0;
    logic [7:0]  lsn = '0;
    logic [14:0] fsa = '0;
    logic [14:0] lsa = '0;
    logic [15:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        error;
    logic        corrupt = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [15:0] smp [0:63];
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    lidar_packet_tx #(.MAX_SAMPLES(MAX)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .start_in        (start),
        .ct_in           (ct),
        .lsn_in          (lsn),
        .fsa_in          (fsa),
        .lsa_in          (lsa),
        .sample_in       (sample),
        .sample_valid_in (sample_valid),
        .sample_ready_out(sample_ready),
        .tx_data_out     (tx_data),
        .tx_valid_out    (tx_valid),
        .tx_ready_in     (tx_ready),
        .busy_out        (busy),
        .done_out        (done),
`ifdef LIDAR_TX_CORRUPT_EN
        .corrupt_in      (corrupt),
`endif
        .error_out       (error)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1);
    end

    // Reference model: packet as a plain list of wire bytes.
    task automatic build_expected(input logic [7:0] c, input logic [7:0] n,
                                  input logic [14:0] f, input logic [14:0] l,
                                  input logic corr);
        logic [15:0] fe, le, cs;
        fe = {f, 1'b1};
        le = {l, 1'b1};
        cs = 16'h55AA ^ {n, c} ^ fe ^ le;
        for (int i = 0; i < int'(n); i++) cs = cs ^ smp[i];
        if (corr) cs[0] = ~cs[0];
        exp_q.delete();
        exp_q.push_back(8'hAA); exp_q.push_back(8'h55);
        exp_q.push_back(c);     exp_q.push_back(n);
        exp_q.push_back(fe[7:0]); exp_q.push_back(fe[15:8]);
        exp_q.push_back(le[7:0]); exp_q.push_back(le[15:8]);
        exp_q.push_back(cs[7:0]); exp_q.push_back(cs[15:8]);
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(smp[i][7:0]);
            exp_q.push_back(smp[i][15:8]);
        end
    endtask

    // Drives one packet starting at the current negedge; expects exp_q.
    task automatic run_packet(input string name, input logic [7:0] c,
                              input logic [7:0] n, input logic [14:0] f,
                              input logic [14:0] l, input logic corr,
                              input int stall_pct, input bit gaps,
                              input bit busy_start, input int abort_after);
        int i, k, cyc;
        logic rdy, v, prev_stall;
        logic [7:0] d, prev_data;
        ct = c; lsn = n; fsa = f; lsa = l; corrupt = corr; start = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        start = busy_start;
        if (busy_start) lsn = 8'd0;
        tests++;
        if (busy !== 1'b1 || sample_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: busy=%b ready=%b, required 1 1", name, busy, sample_ready);
        end
        i = 0; cyc = 0;
        while (i < int'(n) && cyc < 2000) begin
            sample_valid = gaps ? ($urandom_range(2, 0) != 0) : 1'b1;
            sample = sample_valid ? smp[i] : 16'($urandom);
            rdy = sample_ready;
            tests++;
            if (rdy !== 1'b1 || error !== 1'b0) begin
                fails++;
                $display("FAIL %s load: ready=%b error=%b, required 1 0", name, rdy, error);
            end
            @(posedge clk);
            if (sample_valid && rdy) i++;
            @(negedge clk);
            cyc++;
        end
        sample_valid = 1'b0;
        tests++;
        if (i != int'(n) || tx_valid !== 1'b1 || sample_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s first_valid: loaded=%0d tx_valid=%b ready=%b, required %0d 1 0",
                     name, i, tx_valid, sample_ready, n);
        end
        k = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        while (k < exp_q.size() && cyc < 5000) begin
            if (abort_after > 0 && k == abort_after) break;
            rdy = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99, 0)) >= stall_pct);
            tx_ready = rdy;
            v = tx_valid; d = tx_data;
            tests++;
            if (v !== 1'b1 || (busy_start && error !== 1'b0)) begin
                fails++;
                $display("FAIL %s valid: tx_valid=%b error=%b at byte %0d, required 1 0",
                         name, v, error, k);
            end
            if (prev_stall) begin
                tests++;
                if (d !== prev_data) begin
                    fails++;
                    $display("FAIL %s stall_hold: data=%02h, required %02h", name, d, prev_data);
                end
            end
            @(posedge clk);
            if (v && rdy) begin
                tests++;
                if (d !== exp_q[k]) begin
                    fails++;
                    $display("FAIL %s byte[%0d]: got %02h, required %02h", name, k, d, exp_q[k]);
                end
                k++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = v;
                prev_data = d;
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b1;
        if (abort_after > 0) return;
        tests++;
        if (k != exp_q.size() || (stall_pct == 0 && cyc != exp_q.size())) begin
            fails++;
            $display("FAIL %s byte_count: %0d bytes in %0d cycles, required %0d",
                     name, k, cyc, exp_q.size());
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b1 || tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s done: done=%b busy=%b tx_valid=%b, required 1 1 0",
                     name, done, busy, tx_valid);
        end
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL %s idle: done=%b busy=%b error=%b, required 0 0 0",
                     name, done, busy, error);
        end
        $display("[TB] packet %s lsn=%0d bytes=%0d cycles=%0d", name, n, k, cyc);
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if ({sample_ready, tx_valid, busy, done, error} !== 5'b0 || tx_data !== 8'h00) begin
            fails++;
            $display("FAIL %s zero: ready=%b valid=%b busy=%b done=%b error=%b data=%02h, required all 0",
                     name, sample_ready, tx_valid, busy, done, error, tx_data);
        end
    endtask

    task automatic push_vec1(input logic [7:0] cs_lo);
        logic [7:0] bytes [12];
        bytes = '{8'hAA, 8'h55, 8'h01, 8'h01, 8'h01, 8'h20, 8'h01, 8'h20,
                  8'h00, 8'h55, 8'h00, 8'h01};
        bytes[8] = cs_lo;
        exp_q.delete();
        foreach (bytes[j]) exp_q.push_back(bytes[j]);
        smp[0] = 16'h0100;
    endtask

    task automatic push_vec2();
        logic [7:0] bytes [14];
        bytes = '{8'hAA, 8'h55, 8'h00, 8'h02, 8'h01, 8'h00, 8'h01, 8'h00,
                  8'h61, 8'h45, 8'h34, 8'h12, 8'hFF, 8'h00};
        exp_q.delete();
        foreach (bytes[j]) exp_q.push_back(bytes[j]);
        smp[0] = 16'h1234;
        smp[1] = 16'h00FF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1; lsn = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");
        $display("[TB] reset checked");
    endtask

    task automatic test_vectors();
        push_vec1(8'hAB);
        run_packet("vec1", 8'h01, 8'd1, 15'h1000, 15'h1000, 1'b0, 0, 0, 0, 0);
        push_vec2();
        run_packet("vec2", 8'h00, 8'd2, 15'h0000, 15'h0000, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic test_stall();
        push_vec2();
        run_packet("vec2_stall", 8'h00, 8'd2, 15'h0000, 15'h0000, 1'b0, 50, 1, 0, 0);
    endtask

    task automatic test_errors();
        logic [7:0] bad [3];
        bad = '{8'd0, 8'(MAX + 1), 8'hFF};
        foreach (bad[j]) begin
            lsn = bad[j]; ct = 8'h5A; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            tests++;
            if (error !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
                fails++;
                $display("FAIL err_lsn%0d: error=%b busy=%b tx_valid=%b, required 1 0 0",
                         bad[j], error, busy, tx_valid);
            end
            @(negedge clk);
            tests++;
            if (error !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
                fails++;
                $display("FAIL err_pulse%0d: error=%b busy=%b tx_valid=%b, required 0 0 0",
                         bad[j], error, busy, tx_valid);
            end
            $display("[TB] rejected start lsn=%0d", bad[j]);
        end
    endtask

    task automatic test_abort();
        for (int j = 0; j < 4; j++) smp[j] = 16'($urandom);
        build_expected(8'h33, 8'd4, 15'h0123, 15'h4567, 1'b0);
        run_packet("abort", 8'h33, 8'd4, 15'h0123, 15'h4567, 1'b0, 0, 0, 0, 5);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("abort_reset");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("abort_quiet");
        end
        push_vec1(8'hAB);
        run_packet("post_abort", 8'h01, 8'd1, 15'h1000, 15'h1000, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            logic [7:0] c, n;
            logic [14:0] f, l;
            int stall;
            c = 8'($urandom);
            n = (p == 0) ? 8'(MAX) : (p == 1) ? 8'd1 : 8'($urandom_range(MAX, 1));
            f = 15'($urandom);
            l = 15'($urandom);
            stall = (p % 3) * 30;
            for (int j = 0; j < int'(n); j++) smp[j] = 16'($urandom);
            build_expected(c, n, f, l, 1'b0);
            run_packet($sformatf("rand%0d", p), c, n, f, l, 1'b0, stall,
                       (p % 2) == 1, (p % 4) == 2, 0);
        end
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 3; p++) begin
            logic [7:0] n;
            n = 8'($urandom_range(6, 1));
            for (int j = 0; j < int'(n); j++) smp[j] = 16'($urandom);
            build_expected(8'(p), n, 15'(p * 77), 15'(p * 91), 1'b0);
            run_packet($sformatf("b2b%0d", p), 8'(p), n, 15'(p * 77), 15'(p * 91),
                       1'b0, 0, 0, 0, 0);
        end
    endtask

`ifdef LIDAR_TX_CORRUPT_EN
    task automatic test_corrupt();
        push_vec1(8'hAA);
        run_packet("corrupt", 8'h01, 8'd1, 15'h1000, 15'h1000, 1'b1, 0, 0, 0, 0);
        push_vec1(8'hAB);
        run_packet("uncorrupt", 8'h01, 8'd1, 15'h1000, 15'h1000, 1'b0, 0, 0, 0, 0);
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_vectors();
        test_stall();
        test_errors();
        test_abort();
        test_random();
        test_back_to_back();
`ifdef LIDAR_TX_CORRUPT_EN
        test_corrupt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lidar_packet_tx.md
Name: lidar_packet_tx

Overview:
Transmit-side counterpart of the LiDAR packet parser. It builds complete LiDAR scan packets from a header descriptor and a burst of 16-bit distance samples, then serialises them byte-by-byte to the UART transmitter. Each packet contains the 0x55AA header, the CT and LSN bytes, the encoded angles, the XOR checksum and the samples. It serves as a LiDAR emulator for closed-loop testing of the receive path and on-board bring-up.

Parameters:
MAX_SAMPLES, 40, sample buffer depth; legal LSN range is 1..MAX_SAMPLES.

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset, synchronous, active-low
start_in  input  1  packet request; sampled only in IDLE
ct_in  input  8  CT byte, captured on an accepted start
lsn_in  input  8  sample count, captured on an accepted start
fsa_in  input  15  first sample angle, raw
lsa_in  input  15  last sample angle, raw
sample_in  input  16  distance sample
sample_valid_in  input  1  sample_in is valid
sample_ready_out  output  1  block accepts a sample
tx_data_out  output  8  byte to the UART transmitter
tx_valid_out  output  1  tx_data_out is valid
tx_ready_in  input  1  UART transmitter accepts the byte
busy_out  output  1  high whenever the state is not IDLE
done_out  output  1  one-cycle pulse after the last byte is accepted
error_out  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (rst_n_in=0 at a clock edge): state=IDLE. All outputs are 0. The checksum accumulator and all counters are cleared. Asserting reset mid-packet aborts the packet immediately; no further bytes are sent.
- Angle encoding: FSA_E = {fsa_in,1'b1}, LSA_E = {lsa_in,1'b1}. Both are captured at start.
- Checksum, 16-bit XOR: CS = 0x55AA ^ {lsn,ct} ^ FSA_E ^ LSA_E ^ XOR of all samples.
- Wire byte order, all fields little-endian: AA 55 CT LSN FSA_E[7:0] FSA_E[15:8] LSA_E[7:0] LSA_E[15:8] CS[7:0] CS[15:8], then S0[7:0] S0[15:8] ... S(n-1)[15:8].
- IDLE state:
  - start_in=1 with lsn_in=0 or lsn_in>MAX_SAMPLES: error_out pulses for one cycle; the block stays in IDLE.
  - Otherwise: capture the descriptor, seed the accumulator with 0x55AA ^ {lsn,ct} ^ FSA_E ^ LSA_E, go to LOAD.
- LOAD state:
  - sample_ready_out=1.
  - On each sample_valid_in && sample_ready_out: write the sample to buffer[idx], XOR it into the accumulator, increment idx.
  - When the LSN-th sample is accepted, go to SEND_HDR on the next cycle; sample_ready_out is 0 from that cycle on.
  - Samples are never accepted outside LOAD.
- SEND_HDR state:
  - Emits the 10 header bytes using a byte counter 0..9.
  - tx_valid_out is asserted on the first cycle in SEND_HDR, which is 1 cycle after the last sample was accepted.
- Transmit handshake (valid/ready):
  - A byte transfers on tx_valid_out && tx_ready_in.
  - While tx_valid_out=1 and tx_ready_in=0, tx_data_out is held stable.
  - tx_valid_out never drops without a transfer.
  - Back-to-back transfers at one byte per cycle are supported.
- SEND_SAMPLES state: emits the buffered samples, low byte first, from buffer[0] to buffer[LSN-1]. The read is registered and must not insert bubbles when tx_ready_in is held high.
- DONE state: done_out=1 for one cycle, then IDLE. A start_in in this cycle is ignored. The earliest next accepted start is the first IDLE cycle.
- busy_out=1 in LOAD, SEND_HDR, SEND_SAMPLES and DONE.
- start_in while busy is ignored; no error is flagged.
- Total bytes per packet = 10 + 2*LSN.

Optional Feature:
LIDAR_TX_CORRUPT_EN
- Defined: adds input port corrupt_in (1 bit), sampled at an accepted start. If it was 1, the emitted CS has bit 0 inverted, which exercises the receiver's checksum-error path.
- Not defined: the port is absent and CS is always correct.

Test Plan:
- ct=0x01, lsn=1, fsa=0x1000, lsa=0x1000, sample 0x0100, tx_ready_in=1 -> bytes AA 55 01 01 01 20 01 20 AB 55 00 01 on 12 consecutive cycles; done_out pulses once.
- ct=0x00, lsn=2, fsa=0, lsa=0, samples 0x1234 then 0x00FF -> AA 55 00 02 01 00 01 00 61 45 34 12 FF 00.
- Repeat the previous case with tx_ready_in randomly low 50% of the time -> identical byte sequence, and tx_data_out stable during every stall.
- start with lsn=0, then start with lsn=MAX_SAMPLES+1 -> error_out pulses each time; busy_out stays 0; tx_valid_out stays 0.
- rst_n_in=0 for one cycle after the 5th byte of a lsn=4 packet -> all outputs 0 next cycle; a following packet with lsn=1 is correct from AA.
- With LIDAR_TX_CORRUPT_EN defined and corrupt_in=1 on the first test -> CS bytes are AA 55 instead of AB 55; all other bytes unchanged.
